// File: rtl/avalon_sdr_responder.sv
// rtl/avalon_sdr_responder.sv - 16-bit Avalon-MM responder over a word array with programmable stalls,
// pipelined read latency and an outstanding-read limit.
module avalon_sdr_responder #(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 2,
    parameter int WAIT_CYCLES  = 1,
    parameter int MAX_PENDING  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_address,
    input  logic [15:0] avs_s0_writedata,
    input  logic [1:0]  avs_s0_byteenable,
    output logic [15:0] avs_s0_readdata,
    output logic        avs_s0_readdatavalid,
    output logic        avs_s0_waitrequest,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        proto_err,
    output logic [1:0]  track_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(MAX_PENDING + 1) + 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL  = 2'd1,
        ACCEPT = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [PW-1:0]                   pend_q, pend_now;
    logic                            cmd, blocked, wait_c, acc, acc_wr, acc_rd;
    logic [AW-1:0]                   idx;
    logic [15:0]                     mem [DEPTH_WORDS];
    logic [READ_LATENCY-1:0]         vpipe;
    logic [READ_LATENCY:0]           vchain;
    logic [READ_LATENCY-1:0][15:0]   dpipe;
    logic [READ_LATENCY:0][15:0]     dchain;
    logic                            unused_addr;

    assign idx         = avs_s0_address[AW:1];
    assign unused_addr = ^{avs_s0_address[31:AW+1], avs_s0_address[0]};
    assign cmd         = avs_s0_read | avs_s0_write;

    // A read returning this cycle frees its slot for a command accepted in the same cycle.
    assign pend_now = pend_q - PW'(vpipe[READ_LATENCY-1]);
    assign blocked  = cmd && (pend_now == PW'(MAX_PENDING));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_c  = 1'b0;
        acc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd) begin
                    if (WAIT_CYCLES == 0) begin
                        wait_c = blocked;
                        acc    = !blocked;
                    end else begin
                        wait_c  = 1'b1;
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                        state_d = (WAIT_CYCLES == 1) ? ACCEPT : STALL;
                    end
                end
            end
            STALL: begin
                if (!cmd) begin
                    state_d = IDLE;
                end else begin
                    wait_c = 1'b1;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                if (!cmd) begin
                    state_d = IDLE;
                end else if (blocked) begin
                    wait_c = 1'b1;
                end else begin
                    acc     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_wr = acc & reset & avs_s0_write;
    assign acc_rd = acc & reset & avs_s0_read & ~avs_s0_write;

    assign vchain = {vpipe, acc_rd};
    assign dchain = {dpipe, mem[idx]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            vpipe     <= '0;
            dpipe     <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            proto_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_q + PW'(acc_rd) - PW'(vpipe[READ_LATENCY-1]);
            vpipe   <= vchain[READ_LATENCY-1:0];
            // Data only moves with its valid bit, so the output stage holds the last returned word.
            for (int k = 0; k < READ_LATENCY; k++) begin
                if (vchain[k]) dpipe[k] <= dchain[k];
            end
            if (acc_rd) rd_count <= rd_count + 16'd1;
            if (acc_wr) wr_count <= wr_count + 16'd1;
            if (avs_s0_read && avs_s0_write) proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_wr) begin
            if (avs_s0_byteenable[0]) mem[idx][7:0]  <= avs_s0_writedata[7:0];
            if (avs_s0_byteenable[1]) mem[idx][15:8] <= avs_s0_writedata[15:8];
        end
    end

    assign avs_s0_readdata      = dpipe[READ_LATENCY-1];
    assign avs_s0_readdatavalid = vpipe[READ_LATENCY-1];
    assign avs_s0_waitrequest   = !reset | wait_c;
    assign track_state          = state_q;

endmodule

// File: tb/tb_avalon_sdr_responder.sv
// tb/tb_avalon_sdr_responder.sv - scoreboard bench for avalon_sdr_responder in three stall/latency/limit configurations.
module tb_avalon_sdr_responder;

    typedef struct {
        int          inst;
        logic [15:0] d;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd [3];
    logic        wr [3];
    logic [31:0] addr [3];
    logic [15:0] wdata [3];
    logic [1:0]  be [3];
    logic [15:0] rdata [3];
    logic        rdv [3];
    logic        wreq [3];
    logic [15:0] rcnt [3];
    logic [15:0] wcnt [3];
    logic        perr [3];
    logic [1:0]  st [3];

    int WC [3] = '{1, 0, 0};
    int LAT [3] = '{2, 4, 2};
    int MP [3] = '{4, 2, 2};

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    exp_t        sb [$];
    exp_t        acc [$];
    logic [15:0] ref_mem [3][256];
    logic [15:0] last_d [3];
    int          rd_exp [3];
    int          wr_exp [3];
    logic        perr_exp [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_sdr_responder #(.DEPTH_WORDS(256), .READ_LATENCY(2), .WAIT_CYCLES(1), .MAX_PENDING(4)) u_a (
        .clk(clk), .reset(reset), .avs_s0_read(rd[0]), .avs_s0_write(wr[0]), .avs_s0_address(addr[0]),
        .avs_s0_writedata(wdata[0]), .avs_s0_byteenable(be[0]), .avs_s0_readdata(rdata[0]),
        .avs_s0_readdatavalid(rdv[0]), .avs_s0_waitrequest(wreq[0]), .rd_count(rcnt[0]),
        .wr_count(wcnt[0]), .proto_err(perr[0]), .track_state(st[0]));

    avalon_sdr_responder #(.DEPTH_WORDS(256), .READ_LATENCY(4), .WAIT_CYCLES(0), .MAX_PENDING(2)) u_b (
        .clk(clk), .reset(reset), .avs_s0_read(rd[1]), .avs_s0_write(wr[1]), .avs_s0_address(addr[1]),
        .avs_s0_writedata(wdata[1]), .avs_s0_byteenable(be[1]), .avs_s0_readdata(rdata[1]),
        .avs_s0_readdatavalid(rdv[1]), .avs_s0_waitrequest(wreq[1]), .rd_count(rcnt[1]),
        .wr_count(wcnt[1]), .proto_err(perr[1]), .track_state(st[1]));

    avalon_sdr_responder #(.DEPTH_WORDS(256), .READ_LATENCY(2), .WAIT_CYCLES(0), .MAX_PENDING(2)) u_c (
        .clk(clk), .reset(reset), .avs_s0_read(rd[2]), .avs_s0_write(wr[2]), .avs_s0_address(addr[2]),
        .avs_s0_writedata(wdata[2]), .avs_s0_byteenable(be[2]), .avs_s0_readdata(rdata[2]),
        .avs_s0_readdatavalid(rdv[2]), .avs_s0_waitrequest(wreq[2]), .rd_count(rcnt[2]),
        .wr_count(wcnt[2]), .proto_err(perr[2]), .track_state(st[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reads accepted but whose return cycle is still in the future.
    function automatic int pend(input int i);
        int n = 0;
        foreach (acc[j]) if (acc[j].inst == i && acc[j].due > cyc) n++;
        return n;
    endfunction

    task automatic mon(input int i);
        int k = -1;
        foreach (sb[j]) if (k < 0 && sb[j].inst == i) k = j;
        if (rdv[i]) begin
            if (k < 0) begin
                chk($sformatf("rdv_unexpected_u%0d", i), 32'd1, 32'd0);
            end else begin
                chk($sformatf("rdata_u%0d", i), 32'(rdata[i]), 32'(sb[k].d));
                chk($sformatf("rdv_cycle_u%0d", i), 32'(cyc), 32'(sb[k].due));
                sb.delete(k);
            end
            last_d[i] = rdata[i];
        end else begin
            chk($sformatf("rdata_hold_u%0d", i), 32'(rdata[i]), 32'(last_d[i]));
            if (k >= 0 && sb[k].due <= cyc) begin
                chk($sformatf("rdv_missing_u%0d", i), 32'd0, 32'd1);
                sb.delete(k);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) for (int i = 0; i < 3; i++) mon(i);
    end

    task automatic do_cmd(input int i, input bit r, input bit w, input logic [31:0] a,
                          input logic [15:0] d, input logic [1:0] b);
        int   waited = 0;
        int   idx;
        bit   done = 0;
        logic ew;
        rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
        while (!done) begin
            @(negedge clk);
            ew = (waited < WC[i]) || (pend(i) == MP[i]);
            chk($sformatf("waitreq_u%0d", i), 32'(wreq[i]), 32'(ew));
            if (!wreq[i]) begin
                done = 1;
                idx  = int'((a >> 1) % 256);
                if (w) begin
                    if (b[0]) ref_mem[i][idx][7:0] = d[7:0];
                    if (b[1]) ref_mem[i][idx][15:8] = d[15:8];
                    wr_exp[i]++;
                    if (r) perr_exp[i] = 1'b1;
                end else begin
                    sb.push_back('{i, ref_mem[i][idx], cyc + LAT[i]});
                    acc.push_back('{i, 16'h0, cyc + LAT[i]});
                    rd_exp[i]++;
                end
            end else begin
                waited++;
                if (waited > 40) begin
                    chk($sformatf("accept_timeout_u%0d", i), 32'd0, 32'd1);
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
        rd[i] = 1'b0; wr[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_counts(input int i);
        chk($sformatf("rd_count_u%0d", i), 32'(rcnt[i]), 32'(rd_exp[i] % 65536));
        chk($sformatf("wr_count_u%0d", i), 32'(wcnt[i]), 32'(wr_exp[i] % 65536));
        chk($sformatf("proto_err_u%0d", i), 32'(perr[i]), 32'(perr_exp[i]));
    endtask

    task automatic chk_reset(input int i);
        chk($sformatf("rst_rdv_u%0d", i), 32'(rdv[i]), 32'd0);
        chk($sformatf("rst_rdata_u%0d", i), 32'(rdata[i]), 32'd0);
        chk($sformatf("rst_waitreq_u%0d", i), 32'(wreq[i]), 32'd1);
        chk($sformatf("rst_rd_count_u%0d", i), 32'(rcnt[i]), 32'd0);
        chk($sformatf("rst_wr_count_u%0d", i), 32'(wcnt[i]), 32'd0);
        chk($sformatf("rst_proto_err_u%0d", i), 32'(perr[i]), 32'd0);
        chk($sformatf("rst_state_u%0d", i), 32'(st[i]), 32'd0);
    endtask

    task automatic clear_model();
        sb.delete();
        acc.delete();
        for (int i = 0; i < 3; i++) begin
            rd_exp[i] = 0; wr_exp[i] = 0; perr_exp[i] = 1'b0; last_d[i] = 16'h0;
        end
    endtask

    initial begin
        int kind;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; be[i] = '0;
        end
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk_reset(i);
        reset = 1'b1;
        idle(1);

        // Fill every word so later reads never see uninitialised storage.
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 256; w++) do_cmd(i, 0, 1, 32'(w * 2), 16'($urandom), 2'b11);
        idle(6);
        for (int i = 0; i < 3; i++) chk_counts(i);

        do_cmd(0, 0, 1, 32'h10, 16'hBEEF, 2'b11);
        do_cmd(0, 1, 0, 32'h10, 16'h0, 2'b11);
        do_cmd(0, 0, 1, 32'h4, 16'hFFFF, 2'b11);
        do_cmd(0, 0, 1, 32'h4, 16'h1234, 2'b01);
        do_cmd(0, 1, 0, 32'h4, 16'h0, 2'b11);
        do_cmd(0, 0, 1, 32'h4, 16'h0000, 2'b00);
        do_cmd(0, 1, 0, 32'h4, 16'h0, 2'b11);
        do_cmd(0, 0, 1, 32'h200, 16'hA5A5, 2'b11);
        do_cmd(0, 1, 0, 32'h0, 16'h0, 2'b11);
        idle(4);
        chk_counts(0);
        do_cmd(0, 1, 1, 32'h20, 16'h5A5A, 2'b11);
        do_cmd(0, 1, 0, 32'h20, 16'h0, 2'b11);
        idle(4);
        chk_counts(0);
        do_cmd(0, 1, 0, 32'h10, 16'h0, 2'b11);
        idle(4);
        chk_counts(0);

        for (int k = 0; k < 64; k++) do_cmd(2, 0, 1, 32'(2 * k), 16'(k), 2'b11);
        for (int k = 0; k < 64; k++) do_cmd(2, 1, 0, 32'(2 * k), 16'h0, 2'b11);
        for (int k = 0; k < 32; k++) do_cmd(1, 1, 0, 32'(2 * k), 16'h0, 2'b11);
        idle(8);
        for (int i = 0; i < 3; i++) chk_counts(i);

        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 150; k++) begin
                kind = $urandom_range(0, 19);
                if (kind < 9)       do_cmd(i, 0, 1, $urandom, 16'($urandom), 2'($urandom));
                else if (kind < 19) do_cmd(i, 1, 0, $urandom, 16'h0, 2'($urandom));
                else                do_cmd(i, 1, 1, $urandom, 16'($urandom), 2'($urandom));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            idle(8);
            chk_counts(i);
        end

        // Reset with two reads in flight on the long-latency unit.
        do_cmd(1, 1, 0, 32'h10, 16'h0, 2'b11);
        do_cmd(1, 1, 0, 32'h12, 16'h0, 2'b11);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk_reset(i);
        clear_model();
        idle(3);
        reset = 1'b1;
        idle(12);
        for (int i = 0; i < 3; i++) chk_counts(i);
        do_cmd(1, 1, 0, 32'h10, 16'h0, 2'b11);
        do_cmd(0, 1, 0, 32'h4, 16'h0, 2'b11);
        idle(8);
        for (int i = 0; i < 3; i++) chk_counts(i);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
